// File: rtl/nfu3_pkg.sv
// Shared types and default geometry for the nfu_3 controller.
package nfu3_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_TN        = 16;
  localparam int DEF_NSEG      = 16;
  localparam int DEF_LAT       = 2;
  localparam int DEF_DEPTH     = 4;
  localparam int ADDR_W        = 4;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } state_e;

endpackage

// File: rtl/nfu3_out_fifo.sv
// Synchronous circular-buffer FIFO holding nfu_3 results until downstream takes them.
module nfu3_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO may still take a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = i_pop && (count_q != '0);
    do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

endmodule

// File: rtl/nfu3_ctrl.sv
// Controller for the nfu_3 stage: coefficient table reload, credit-limited
// vector issue into the fixed-latency datapath and buffering of its results.
module nfu3_ctrl
  import nfu3_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int Tn        = DEF_TN,
  parameter int NSEG      = DEF_NSEG,
  parameter int LAT       = DEF_LAT,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cfg_start,
  input  logic                    i_coef_valid,
  input  logic [2*BIT_WIDTH-1:0]  i_coef_data,
  output logic                    o_coef_ready,
  output logic [2*BIT_WIDTH-1:0]  o_sig_coef,
  output logic                    o_sig_load_coef,
  output logic [ADDR_W-1:0]       o_sig_addr,
  output logic                    o_sig_addr_sel,
  input  logic                    i_in_valid,
  input  logic [Tn*BIT_WIDTH-1:0] i_in_data,
  output logic                    o_in_ready,
  output logic [Tn*BIT_WIDTH-1:0] o_dp_x,
  input  logic [Tn*BIT_WIDTH-1:0] i_dp_y,
  output logic                    o_out_valid,
  output logic [Tn*BIT_WIDTH-1:0] o_out_data,
  input  logic                    i_out_ready,
  output logic                    o_cfg_done
);

  localparam int VW     = Tn * BIT_WIDTH;
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int IF_W   = $clog2(LAT + 1);
  localparam int SUM_W  = $clog2(DEPTH + LAT + 2) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [LAT-1:0]    vpipe_q, vpipe_d;
  logic [FCNT_W-1:0] fifo_count;
  logic [IF_W-1:0]   inflight;
  logic [SUM_W-1:0]  occupancy;
  logic              room;
  logic              accept;
  logic              push;
  logic              pop;

  // Every vector already issued owns a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + IF_W'(vpipe_q[i]);
    end
    occupancy = SUM_W'(fifo_count) + SUM_W'(inflight) + SUM_W'(1);
    room      = (occupancy <= SUM_W'(DEPTH));
  end

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    o_coef_ready    = 1'b0;
    o_sig_addr_sel  = 1'b0;
    o_sig_load_coef = 1'b0;
    o_sig_coef      = '0;
    o_sig_addr      = '0;
    o_cfg_done      = 1'b0;
    o_in_ready      = 1'b0;
    case (state_q)
      UNCFG: begin
        if (i_cfg_start) begin
          state_d = LOAD;
          word_d  = '0;
        end
      end
      LOAD: begin
        o_coef_ready   = 1'b1;
        o_sig_addr_sel = 1'b1;
        o_sig_addr     = word_q;
        if (i_coef_valid) begin
          o_sig_load_coef = 1'b1;
          o_sig_coef      = i_coef_data;
          if (word_q == ADDR_W'(NSEG - 1)) begin
            state_d = RUN;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        o_cfg_done = 1'b1;
        if (inflight == '0) begin
          state_d = LOAD;
          word_d  = '0;
        end
      end
      RUN: begin
        o_cfg_done = 1'b1;
        o_in_ready = room;
        if (i_cfg_start) begin
          state_d = DRAIN;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_comb begin
    accept     = o_in_ready && i_in_valid;
    o_dp_x     = accept ? i_in_data : '0;
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = accept;
    push       = vpipe_q[LAT-1];
    pop        = o_out_valid && i_out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNCFG;
      word_q  <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      vpipe_q <= vpipe_d;
    end
  end

  nfu3_out_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (push),
    .i_push_data (i_dp_y),
    .i_pop       (pop),
    .o_head      (o_out_data),
    .o_count     (fifo_count)
  );

  assign o_out_valid = (fifo_count != '0);

endmodule

// File: tb/tb_nfu3_ctrl.sv
// Self-checking bench for nfu3_ctrl: directed table, multi-cycle sequences and
// randomized traffic against a queue-based transaction model.
module tb_nfu3_ctrl;

  localparam int BW    = 16;
  localparam int TN    = 16;
  localparam int NSEG  = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int VW    = TN * BW;
  localparam int CW    = 2 * BW;

  logic          clk;
  logic          rst_n;
  logic          i_cfg_start;
  logic          i_coef_valid;
  logic [CW-1:0] i_coef_data;
  logic          o_coef_ready;
  logic [CW-1:0] o_sig_coef;
  logic          o_sig_load_coef;
  logic [3:0]    o_sig_addr;
  logic          o_sig_addr_sel;
  logic          i_in_valid;
  logic [VW-1:0] i_in_data;
  logic          o_in_ready;
  logic [VW-1:0] o_dp_x;
  logic [VW-1:0] i_dp_y;
  logic          o_out_valid;
  logic [VW-1:0] o_out_data;
  logic          i_out_ready;
  logic          o_cfg_done;

  nfu3_ctrl #(
    .BIT_WIDTH (BW),
    .Tn        (TN),
    .NSEG      (NSEG),
    .LAT       (LAT),
    .DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cfg_start     (i_cfg_start),
    .i_coef_valid    (i_coef_valid),
    .i_coef_data     (i_coef_data),
    .o_coef_ready    (o_coef_ready),
    .o_sig_coef      (o_sig_coef),
    .o_sig_load_coef (o_sig_load_coef),
    .o_sig_addr      (o_sig_addr),
    .o_sig_addr_sel  (o_sig_addr_sel),
    .i_in_valid      (i_in_valid),
    .i_in_data       (i_in_data),
    .o_in_ready      (o_in_ready),
    .o_dp_x          (o_dp_x),
    .i_dp_y          (i_dp_y),
    .o_out_valid     (o_out_valid),
    .o_out_data      (o_out_data),
    .i_out_ready     (i_out_ready),
    .o_cfg_done      (o_cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the nfu_3 datapath: LAT-cycle pipeline returning the inverted input.
  logic [VW-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= o_dp_x;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign i_dp_y = ~dp_pipe[LAT-1];

  typedef enum int {M_UNCFG, M_LOAD, M_DRAIN, M_RUN} mode_t;
  typedef struct {
    logic [VW-1:0] data;
    int            due;
  } flight_t;
  typedef struct {
    bit            cs;
    bit            cv;
    logic [CW-1:0] cd;
    bit            expCoefReady;
    bit            expLoad;
    logic [3:0]    expAddr;
    bit            expDone;
    bit            expInReady;
  } vec_t;

  mode_t         mMode;
  int            mWords;
  int            mAccTotal;
  flight_t       mFlight[$];
  logic [VW-1:0] mFifo[$];
  int            cyc;
  int            obsPop;
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit mInReady();
    return (mMode == M_RUN) && (mFifo.size() + mFlight.size() + 1 <= DEPTH);
  endfunction

  task automatic modelReset();
    mMode  = M_UNCFG;
    mWords = 0;
    mFlight.delete();
    mFifo.delete();
  endtask

  task automatic checkOutput();
    bit            expReady;
    bit            expLoad;
    logic [VW-1:0] expHead;
    expReady = mInReady();
    expLoad  = (mMode == M_LOAD) && i_coef_valid;
    expHead  = (mFifo.size() > 0) ? mFifo[0] : '0;
    check("in_ready",   VW'(o_in_ready),      VW'(expReady));
    check("out_valid",  VW'(o_out_valid),     VW'(mFifo.size() > 0));
    check("out_data",   o_out_data,           expHead);
    check("coef_ready", VW'(o_coef_ready),    VW'(mMode == M_LOAD));
    check("addr_sel",   VW'(o_sig_addr_sel),  VW'(mMode == M_LOAD));
    check("load_coef",  VW'(o_sig_load_coef), VW'(expLoad));
    check("cfg_done",   VW'(o_cfg_done),      VW'(mMode == M_RUN || mMode == M_DRAIN));
    check("dp_x",       o_dp_x,               (expReady && i_in_valid) ? i_in_data : '0);
    if (expLoad) begin
      check("sig_addr", VW'(o_sig_addr), VW'(mWords));
      check("sig_coef", VW'(o_sig_coef), VW'(i_coef_data));
    end
  endtask

  task automatic modelAdvance();
    bit            acc;
    bit            pop;
    mode_t         nxt;
    flight_t       f;
    logic [VW-1:0] dummy;
    acc = mInReady() && i_in_valid;
    pop = (mFifo.size() > 0) && i_out_ready;
    nxt = mMode;
    case (mMode)
      M_UNCFG: if (i_cfg_start) begin nxt = M_LOAD; mWords = 0; end
      M_LOAD: begin
        if (i_coef_valid) begin
          mWords++;
          if (mWords == NSEG) begin nxt = M_RUN; mWords = 0; end
        end
      end
      M_RUN:   if (i_cfg_start) nxt = M_DRAIN;
      M_DRAIN: if (mFlight.size() == 0) begin nxt = M_LOAD; mWords = 0; end
      default: nxt = M_UNCFG;
    endcase
    if (pop) dummy = mFifo.pop_front();
    if (mFlight.size() > 0 && mFlight[0].due == cyc) begin
      f = mFlight.pop_front();
      mFifo.push_back(~f.data);
    end
    if (acc) begin
      f.data = i_in_data;
      f.due  = cyc + LAT;
      mFlight.push_back(f);
      mAccTotal++;
    end
    mMode = nxt;
    cyc++;
  endtask

  task automatic applyStimulus(input bit cs, input bit cv, input logic [CW-1:0] cd,
                               input bit iv, input logic [VW-1:0] id, input bit ordy);
    i_cfg_start  = cs;
    i_coef_valid = cv;
    i_coef_data  = cd;
    i_in_valid   = iv;
    i_in_data    = id;
    i_out_ready  = ordy;
  endtask

  task automatic tickTail();
    checkOutput();
    if (o_out_valid && i_out_ready) obsPop++;
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    tickTail();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready",  VW'(o_in_ready),      VW'(0));
    check("rst_out_valid", VW'(o_out_valid),     VW'(0));
    check("rst_out_data",  o_out_data,           VW'(0));
    check("rst_coef_rdy",  VW'(o_coef_ready),    VW'(0));
    check("rst_load_coef", VW'(o_sig_load_coef), VW'(0));
    check("rst_addr_sel",  VW'(o_sig_addr_sel),  VW'(0));
    check("rst_sig_addr",  VW'(o_sig_addr),      VW'(0));
    check("rst_sig_coef",  VW'(o_sig_coef),      VW'(0));
    check("rst_cfg_done",  VW'(o_cfg_done),      VW'(0));
    check("rst_dp_x",      o_dp_x,               VW'(0));
    modelReset();
    applyStimulus(0, 0, '0, 0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkVec(input bit cs, input bit cv, input logic [CW-1:0] cd,
                                 input bit ecr, input bit eld, input logic [3:0] ea,
                                 input bit edn, input bit eir);
    vec_t v;
    v.cs = cs; v.cv = cv; v.cd = cd;
    v.expCoefReady = ecr; v.expLoad = eld; v.expAddr = ea;
    v.expDone = edn; v.expInReady = eir;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          tbl[$];
    int            strobes;
    int            firstAcc;
    int            firstOut;
    int            accBase;
    int            popBase;
    int            loadIdx;
    logic [CW-1:0] w;

    tests = 0; fails = 0; cyc = 0; obsPop = 0; mAccTotal = 0;
    rst_n = 1'b0;
    applyStimulus(0, 0, '0, 0, '0, 0);
    modelReset();
    #2;
    doReset();

    // Coefficient load with valid gaps; one gap also pulses cfg_start inside LOAD.
    tbl.push_back(mkVec(1, 0, '0, 0, 0, 4'd0, 0, 0));
    for (int k = 0; k < NSEG; k++) begin
      if (k % 3 == 1) tbl.push_back(mkVec(k == 4, 0, '0, 1, 0, 4'd0, 0, 0));
      w = 32'h0001_0000 + CW'(k);
      tbl.push_back(mkVec(0, 1, w, 1, 1, 4'(k), 0, 0));
    end
    tbl.push_back(mkVec(0, 0, '0, 0, 0, 4'd0, 1, 1));
    tbl.push_back(mkVec(0, 0, '0, 0, 0, 4'd0, 1, 1));

    strobes = 0;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].cs, tbl[i].cv, tbl[i].cd, 0, '0, 1);
      @(negedge clk);
      check("tbl_coef_ready", VW'(o_coef_ready),    VW'(tbl[i].expCoefReady));
      check("tbl_load",       VW'(o_sig_load_coef), VW'(tbl[i].expLoad));
      check("tbl_cfg_done",   VW'(o_cfg_done),      VW'(tbl[i].expDone));
      check("tbl_in_ready",   VW'(o_in_ready),      VW'(tbl[i].expInReady));
      if (tbl[i].expLoad) check("tbl_addr", VW'(o_sig_addr), VW'(tbl[i].expAddr));
      if (o_sig_load_coef) strobes++;
      tickTail();
    end
    check("strobe_count", VW'(strobes), VW'(NSEG));

    // Back-to-back stream of 20 vectors with the sink always ready.
    firstAcc = -1;
    firstOut = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, '0, 1, randVec(), 1);
      @(negedge clk);
      check("stream_ready", VW'(o_in_ready), VW'(1));
      if (firstAcc < 0) firstAcc = cyc;
      if (o_out_valid && firstOut < 0) firstOut = cyc;
      tickTail();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, '0, 0, '0, 1);
      @(negedge clk);
      if (o_out_valid && firstOut < 0) firstOut = cyc;
      tickTail();
    end
    check("stream_latency", VW'(firstOut - firstAcc), VW'(LAT + 1));

    // Sink stalls for 10 cycles while the source keeps offering vectors.
    accBase = mAccTotal;
    popBase = obsPop;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, '0, 1, randVec(), 0);
      @(negedge clk);
      if (i == 9) check("bp_in_ready_low", VW'(o_in_ready), VW'(0));
      tickTail();
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, '0, 1, randVec(), 1);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, '0, 0, '0, 1);
      tick();
    end
    check("bp_no_loss", VW'(obsPop - popBase), VW'(mAccTotal - accBase));

    // Reconfiguration requested with two vectors in flight.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, '0, 1, randVec(), 1);
      tick();
    end
    applyStimulus(1, 0, '0, 0, '0, 1);
    tick();
    loadIdx = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, '0, 1, randVec(), 1);
      @(negedge clk);
      check("drain_no_accept", VW'(o_in_ready), VW'(0));
      if (o_coef_ready && loadIdx < 0) loadIdx = i;
      tickTail();
      if (loadIdx >= 0) break;
    end
    check("drain_to_load", VW'(loadIdx), VW'(2));
    for (int k = 0; k < NSEG; k++) begin
      applyStimulus(0, 1, CW'($urandom), 1, randVec(), 1);
      tick();
    end
    applyStimulus(0, 0, '0, 0, '0, 1);
    @(negedge clk);
    check("reload_done", VW'(o_cfg_done), VW'(1));
    tickTail();

    // Reset in the middle of a reload after 7 words.
    applyStimulus(1, 0, '0, 0, '0, 1);
    tick();
    applyStimulus(0, 0, '0, 0, '0, 1);
    tick();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 1, CW'($urandom), 0, '0, 1);
      tick();
    end
    applyStimulus(0, 1, CW'($urandom), 1, randVec(), 1);
    doReset();
    applyStimulus(0, 0, '0, 0, '0, 1);
    @(negedge clk);
    check("post_reset_done", VW'(o_cfg_done), VW'(0));
    tickTail();
    applyStimulus(1, 0, '0, 0, '0, 1);
    tick();
    applyStimulus(0, 1, 32'h0001_0000, 0, '0, 1);
    @(negedge clk);
    check("reload_addr0", VW'(o_sig_addr), VW'(0));
    check("reload_load0", VW'(o_sig_load_coef), VW'(1));
    tickTail();
    for (int k = 1; k < NSEG; k++) begin
      applyStimulus(0, 1, 32'h0001_0000 + CW'(k), 0, '0, 1);
      tick();
    end

    // Randomized traffic with occasional reconfiguration.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), CW'($urandom),
                    1'($urandom_range(0, 1)), randVec(), $urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nfu3_ctrl.md
NFU3_CTRL -- requirements
Module: nfu3_ctrl

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH, default 16, element width; Tn, default 16, lanes; NSEG, default 16, coefficient entries; LAT, default 2, nfu_3 input-to-output cycles; DEPTH, default 4, output FIFO entries.
REQ-002 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_cfg_start  in  1  pulse, begin coefficient reload
- i_coef_valid  in  1  coefficient word valid
- i_coef_data  in  2*BIT_WIDTH  {ai,bi} word
- o_coef_ready  out  1  coefficient word accepted
- o_sig_coef  out  2*BIT_WIDTH  coefficient write data to nfu_3
- o_sig_load_coef  out  1  coefficient write strobe to nfu_3
- o_sig_addr  out  4  coefficient write address
- o_sig_addr_sel  out  1  1 = datapath RAM uses o_sig_addr
- i_in_valid  in  1  NFU-2 vector valid
- i_in_data  in  Tn*BIT_WIDTH  NFU-2 vector
- o_in_ready  out  1  vector accepted
- o_dp_x  out  Tn*BIT_WIDTH  nfu_3 input
- i_dp_y  in  Tn*BIT_WIDTH  nfu_3 output
- o_out_valid  out  1  result valid
- o_out_data  out  Tn*BIT_WIDTH  result vector
- i_out_ready  in  1  downstream ready
- o_cfg_done  out  1  coefficient table valid

Function
REQ-004 FSM states SHALL be UNCFG, LOAD, DRAIN, RUN; reset state UNCFG.
REQ-005 UNCFG->LOAD on i_cfg_start; RUN->DRAIN on i_cfg_start; DRAIN->LOAD when in-flight count is 0; LOAD->RUN after NSEG words accepted; i_cfg_start in LOAD or DRAIN SHALL be ignored.
REQ-006 In LOAD: o_coef_ready=1, o_sig_addr_sel=1; each cycle with i_coef_valid SHALL assert o_sig_load_coef for that cycle, o_sig_coef=i_coef_data, o_sig_addr=word counter; counter increments 0..NSEG-1 and clears on entry to LOAD.
REQ-007 o_cfg_done SHALL be 0 from entry to LOAD until the transition to RUN, 1 in RUN and DRAIN.
REQ-008 Input accepted (i_in_valid & o_in_ready) only in RUN and only when fifo_count + inflight + 1 <= DEPTH; same-cycle FIFO pop is not credited.
REQ-009 o_dp_x SHALL equal i_in_data on an accept cycle, all-zero otherwise.
REQ-010 A LAT-bit valid shift register SHALL track in-flight vectors; when its tail bit is 1, i_dp_y SHALL be pushed into the FIFO that cycle (latency input-accept to FIFO write exactly LAT cycles).
REQ-011 o_out_valid = FIFO non-empty; o_out_data = FIFO head; pop on o_out_valid & i_out_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-012 FIFO overflow is impossible by REQ-008; FIFO SHALL keep draining in DRAIN and LOAD.
REQ-013 Throughput SHALL be 1 vector/cycle in steady state with i_out_ready held 1 and DEPTH >= LAT+2.

Reset
REQ-014 rst_n low SHALL immediately force: state UNCFG, counters 0, valid pipe 0, FIFO empty, all outputs 0 (o_cfg_done=0, o_in_ready=0, o_coef_ready=0, o_sig_load_coef=0).
REQ-015 Reset mid-LOAD SHALL discard partial table; o_cfg_done stays 0 until a full reload completes.

Structure
REQ-016 Package nfu3_pkg SHALL hold the state enum and default BIT_WIDTH, Tn, NSEG, LAT, DEPTH constants.
REQ-017 Output FIFO SHALL be a sub-module nfu3_out_fifo (sync, parameterised width/depth, count output).

Verification
REQ-018 Load: i_cfg_start, 16 words 0x00010000+k with valid gaps -> 16 strobes, addresses 0..15 in order, o_cfg_done=1 the cycle after the 16th.
REQ-019 Stream: 20 vectors back-to-back, i_out_ready=1 -> all accepted consecutively, each result at FIFO LAT cycles after accept, order preserved.
REQ-020 Backpressure: i_out_ready=0 for 10 cycles during stream -> at most DEPTH results held, o_in_ready falls, no loss/duplication after release.
REQ-021 Reconfig: i_cfg_start with 2 vectors in flight -> DRAIN until both pushed, then LOAD; no input accepted meanwhile.
REQ-022 Reset after 7 coefficient words -> all outputs 0; new i_cfg_start reloads from address 0.
REQ-023 i_cfg_start pulsed during LOAD -> ignored, counter unaffected.
